// File: rtl/preg_freelist.sv
// preg_freelist: circular free list of physical register ids for rename.
// Head supplies the next id to allocate, tail receives ids released at
// commit; count tracks how many ids are currently free.
// Optional feature macro: FREELIST_CHECK_EN adds a busy bitmap that
// detects and drops double frees.

package C;
    localparam int PREG_ID_BITS = 4;
    localparam int PRFSIZE      = 2 ** PREG_ID_BITS;
    typedef logic [PREG_ID_BITS-1:0] preg_id_t;
endpackage

module preg_freelist #(
    parameter int PRF_SIZE  = C::PRFSIZE,
    parameter int PREG_BITS = C::PREG_ID_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_req_i,
    output logic                 alloc_ready_o,
    output C::preg_id_t          alloc_preg_o,
    input  logic                 free_valid_i,
    input  logic [PREG_BITS-1:0] free_preg_i,
    input  logic                 flush_i,
    output logic [PREG_BITS:0]   free_count_o,
    output logic                 error_o
);

    localparam logic [PREG_BITS:0] FULL_COUNT = (PREG_BITS+1)'(PRF_SIZE);

    // Queue entries, one register per slot so each can reload its own index
    logic [PREG_BITS-1:0] storage [PRF_SIZE];

    logic [PREG_BITS-1:0] head_q, head_d;
    logic [PREG_BITS-1:0] tail_q, tail_d;
    logic [PREG_BITS:0]   count_q, count_d;
    logic                 error_q, error_d;

    logic grant;
    logic full;
    logic free_legal;
    logic free_accept;
    logic free_error;

    // Handshake outputs come purely from registered state: a free issued
    // this cycle is never visible at the allocation port until next cycle.
    assign alloc_ready_o = (count_q != '0);
    assign alloc_preg_o  = storage[head_q];
    assign free_count_o  = count_q;
    assign error_o       = error_q;

    assign grant = alloc_req_i && (count_q != '0);
    assign full  = (count_q == FULL_COUNT);

`ifdef FREELIST_CHECK_EN
    // Bit set means the preg is currently handed out to the pipeline
    logic [PRF_SIZE-1:0] busy_q, busy_d;

    assign free_legal = busy_q[free_preg_i];

    // Track outstanding ids; flush returns every id to the free state
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (grant) begin
                busy_d[alloc_preg_o] = 1'b1;
            end
            if (free_accept) begin
                busy_d[free_preg_i] = 1'b0;
            end
        end
    end

    // Busy bitmap register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    assign free_legal = 1'b1;
`endif

    // A free is enqueued only when there is room and (if checked) the id
    // is really outstanding; anything else is a protocol violation.
    assign free_accept = free_valid_i && !full && free_legal;
    assign free_error  = free_valid_i && (full || !free_legal);

    // Pointer, count and sticky-error next state; flush wins over traffic
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        error_d = error_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = FULL_COUNT;
        end else begin
            if (grant) begin
                head_d = head_q + 1'b1;
            end
            if (free_accept) begin
                tail_d = tail_q + 1'b1;
            end
            case ({grant, free_accept})
                2'b10:   count_d = count_q - 1'b1;
                2'b01:   count_d = count_q + 1'b1;
                default: count_d = count_q;
            endcase
            error_d = error_q | free_error;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FULL_COUNT;
            error_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    generate
        for (genvar gi = 0; gi < PRF_SIZE; gi++) begin : g_slot
            logic [PREG_BITS-1:0] entry_q;

            // Slot reloads its own index on reset/flush, else captures frees at tail
            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    entry_q <= PREG_BITS'(gi);
                end else if (free_accept && (tail_q == PREG_BITS'(gi))) begin
                    entry_q <= free_preg_i;
                end
            end

            assign storage[gi] = entry_q;
        end
    endgenerate

endmodule

// File: tb/tb_preg_freelist.sv
// Directed testbench for preg_freelist (default 16-entry configuration).
module tb_preg_freelist;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       alloc_req_i;
    logic       alloc_ready_o;
    logic [3:0] alloc_preg_o;
    logic       free_valid_i;
    logic [3:0] free_preg_i;
    logic       flush_i;
    logic [4:0] free_count_o;
    logic       error_o;

    int n_cmp = 0;
    int n_err = 0;

    preg_freelist dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alloc_req_i   (alloc_req_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_preg_o  (alloc_preg_o),
        .free_valid_i  (free_valid_i),
        .free_preg_i   (free_preg_i),
        .flush_i       (flush_i),
        .free_count_o  (free_count_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        alloc_req_i = 1'b0;
        free_valid_i = 1'b0;
        free_preg_i = 4'd0;
        flush_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
        n_cmp++; if (alloc_preg_o !== 4'd0) begin n_err++; $display("FAIL reset_preg got=%0d exp=0", alloc_preg_o); end
        n_cmp++; if (free_count_o !== 5'd16) begin n_err++; $display("FAIL reset_count got=%0d exp=16", free_count_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error got=%b exp=0", error_o); end
        $display("test_reset: ready=%b preg=%0d count=%0d err=%b", alloc_ready_o, alloc_preg_o, free_count_o, error_o);
    endtask

    // 16 back-to-back grants in id order, then empty; alloc while empty is ignored
    task automatic test_alloc_all();
        logic [3:0] exp_id;
        for (int i = 0; i < 16; i++) begin
            exp_id = 4'(i);
            alloc_req_i = 1'b1;
            n_cmp++; if (alloc_ready_o !== 1'b1 || alloc_preg_o !== exp_id) begin
                n_err++; $display("FAIL alloc_order[%0d] got ready=%b id=%0d exp ready=1 id=%0d", i, alloc_ready_o, alloc_preg_o, exp_id);
            end
            $display("alloc: cycle %0d id=%0d", i, alloc_preg_o);
            step();
        end
        n_cmp++; if (alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL empty_ready got=%b exp=0", alloc_ready_o); end
        n_cmp++; if (free_count_o !== 5'd0) begin n_err++; $display("FAIL empty_count got=%0d exp=0", free_count_o); end
        step(); // alloc_req still high while empty
        alloc_req_i = 1'b0;
        n_cmp++; if (free_count_o !== 5'd0 || error_o !== 1'b0) begin
            n_err++; $display("FAIL alloc_when_empty got count=%0d err=%b exp count=0 err=0", free_count_o, error_o);
        end
    endtask

    // Free 7 into an empty list: not visible in same cycle, visible next cycle
    task automatic test_free_from_empty();
        free_valid_i = 1'b1;
        free_preg_i = 4'd7;
        #1;
        n_cmp++; if (alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL bypass_ready got=%b exp=0", alloc_ready_o); end
        step();
        free_valid_i = 1'b0;
        n_cmp++; if (alloc_ready_o !== 1'b1 || alloc_preg_o !== 4'd7 || free_count_o !== 5'd1) begin
            n_err++; $display("FAIL free_latency got ready=%b id=%0d count=%0d exp ready=1 id=7 count=1", alloc_ready_o, alloc_preg_o, free_count_o);
        end
        $display("free: id=7 -> ready=%b head=%0d count=%0d", alloc_ready_o, alloc_preg_o, free_count_o);
    endtask

    // Bring count to 5 (7,9,10,11,12), alloc+free 3 together, then drain
    task automatic test_simultaneous();
        logic [3:0] fill [4];
        logic [3:0] drain [5];
        fill = '{4'd9, 4'd10, 4'd11, 4'd12};
        drain = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd3};
        for (int i = 0; i < 4; i++) begin
            free_valid_i = 1'b1;
            free_preg_i = fill[i];
            step();
        end
        free_valid_i = 1'b0;
        n_cmp++; if (free_count_o !== 5'd5) begin n_err++; $display("FAIL fill_count got=%0d exp=5", free_count_o); end
        alloc_req_i = 1'b1;
        free_valid_i = 1'b1;
        free_preg_i = 4'd3;
        #1;
        n_cmp++; if (alloc_preg_o !== 4'd7) begin n_err++; $display("FAIL simul_grant got=%0d exp=7", alloc_preg_o); end
        step();
        free_valid_i = 1'b0;
        n_cmp++; if (free_count_o !== 5'd5) begin n_err++; $display("FAIL simul_count got=%0d exp=5", free_count_o); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (alloc_preg_o !== drain[i]) begin
                n_err++; $display("FAIL simul_drain[%0d] got=%0d exp=%0d", i, alloc_preg_o, drain[i]);
            end
            $display("drain: id=%0d", alloc_preg_o);
            step();
        end
        alloc_req_i = 1'b0;
        n_cmp++; if (free_count_o !== 5'd0) begin n_err++; $display("FAIL drain_count got=%0d exp=0", free_count_o); end
    endtask

    // 20 pipelined free/alloc pairs wrapping the pointers; order preserved
    task automatic test_wrap();
        logic [3:0] f_id;
        logic [3:0] exp_id;
        for (int k = 0; k <= 20; k++) begin
            f_id = 4'((k * 5 + 3) % 16);
            exp_id = 4'(((k - 1) * 5 + 3) % 16);
            free_valid_i = (k < 20);
            free_preg_i = f_id;
            alloc_req_i = (k > 0);
            if (k > 0) begin
                n_cmp++; if (alloc_ready_o !== 1'b1 || alloc_preg_o !== exp_id) begin
                    n_err++; $display("FAIL wrap_order[%0d] got ready=%b id=%0d exp id=%0d", k, alloc_ready_o, alloc_preg_o, exp_id);
                end
            end
            step();
            n_cmp++; if (free_count_o > 5'd16 || free_count_o !== ((k < 20) ? 5'd1 : 5'd0)) begin
                n_err++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", k, free_count_o, (k < 20) ? 1 : 0);
            end
            $display("wrap: pair %0d freed=%0d count=%0d", k, f_id, free_count_o);
        end
        free_valid_i = 1'b0;
        alloc_req_i = 1'b0;
    endtask

    // Free into a full list sets sticky error, which survives flush
    task automatic test_overflow_error();
        do_reset();
        free_valid_i = 1'b1;
        free_preg_i = 4'd2;
        step();
        free_valid_i = 1'b0;
        n_cmp++; if (error_o !== 1'b1 || free_count_o !== 5'd16) begin
            n_err++; $display("FAIL overflow got err=%b count=%0d exp err=1 count=16", error_o, free_count_o);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL error_sticky_flush got=%b exp=1", error_o); end
        $display("overflow: err=%b count=%0d", error_o, free_count_o);
`ifdef FREELIST_CHECK_EN
        do_reset();
        alloc_req_i = 1'b1;
        step();
        alloc_req_i = 1'b0;
        free_valid_i = 1'b1;
        free_preg_i = 4'd0;
        step();
        n_cmp++; if (error_o !== 1'b0 || free_count_o !== 5'd16) begin
            n_err++; $display("FAIL legal_free got err=%b count=%0d exp err=0 count=16", error_o, free_count_o);
        end
        step();
        free_valid_i = 1'b0;
        n_cmp++; if (error_o !== 1'b1 || free_count_o !== 5'd16) begin
            n_err++; $display("FAIL double_free got err=%b count=%0d exp err=1 count=16", error_o, free_count_o);
        end
        $display("double_free: err=%b count=%0d", error_o, free_count_o);
`endif
    endtask

    // Flush with concurrent alloc restores the full list; reset discards allocations
    task automatic test_flush();
        logic [3:0] exp_id;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_id = 4'(i);
            alloc_req_i = 1'b1;
            n_cmp++; if (alloc_preg_o !== exp_id) begin n_err++; $display("FAIL flush_pre[%0d] got=%0d exp=%0d", i, alloc_preg_o, exp_id); end
            step();
        end
        n_cmp++; if (free_count_o !== 5'd10) begin n_err++; $display("FAIL flush_precount got=%0d exp=10", free_count_o); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        alloc_req_i = 1'b0;
        n_cmp++; if (free_count_o !== 5'd16 || alloc_preg_o !== 4'd0 || alloc_ready_o !== 1'b1) begin
            n_err++; $display("FAIL flush_restore got count=%0d id=%0d ready=%b exp count=16 id=0 ready=1", free_count_o, alloc_preg_o, alloc_ready_o);
        end
        $display("flush: count=%0d head=%0d", free_count_o, alloc_preg_o);
        alloc_req_i = 1'b1;
        step(); step(); step();
        n_cmp++; if (free_count_o !== 5'd13 || alloc_preg_o !== 4'd3) begin
            n_err++; $display("FAIL midop_pre got count=%0d id=%0d exp count=13 id=3", free_count_o, alloc_preg_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        alloc_req_i = 1'b0;
        n_cmp++; if (free_count_o !== 5'd16 || alloc_preg_o !== 4'd0 || error_o !== 1'b0) begin
            n_err++; $display("FAIL midop_reset got count=%0d id=%0d err=%b exp count=16 id=0 err=0", free_count_o, alloc_preg_o, error_o);
        end
        $display("reset mid-op: count=%0d head=%0d", free_count_o, alloc_preg_o);
    endtask

    initial begin
        rst_i = 1'b1;
        alloc_req_i = 1'b0;
        free_valid_i = 1'b0;
        free_preg_i = 4'd0;
        flush_i = 1'b0;
        test_reset();
        test_alloc_all();
        test_free_from_empty();
        test_simultaneous();
        test_wrap();
        test_overflow_error();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
- REQ-001 SHALL have parameter PRF_SIZE, default C::PRFSIZE (16): number of physical registers managed.
- REQ-002 SHALL have parameter PREG_BITS, default C::PREG_ID_BITS (4): width of a physical register id; PRF_SIZE = 2**PREG_BITS.
- REQ-003 SHALL have port clk_i, input, 1: single clock, all state updates on rising edge.
- REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
- REQ-005 SHALL have port alloc_req_i, input, 1: rename stage requests one destination preg this cycle.
- REQ-006 SHALL have port alloc_ready_o, output, 1: list non-empty; an allocation is granted when alloc_req_i && alloc_ready_o.
- REQ-007 SHALL have port alloc_preg_o, output, PREG_BITS: preg id granted (value of head entry); type C::preg_id_t.
- REQ-008 SHALL have port free_valid_i, input, 1: commit stage releases one preg this cycle.
- REQ-009 SHALL have port free_preg_i, input, PREG_BITS: preg id released.
- REQ-010 SHALL have port flush_i, input, 1: pipeline squash; restore list to all-free.
- REQ-011 SHALL have port free_count_o, output, PREG_BITS+1: number of free entries.
- REQ-012 SHALL have port error_o, output, 1: sticky protocol-violation flag.

Function
- REQ-013 SHALL implement a circular FIFO of PRF_SIZE entries with head pointer, tail pointer (PREG_BITS each, wrap modulo PRF_SIZE) and count register.
- REQ-014 SHALL drive alloc_ready_o = (count != 0) and alloc_preg_o = storage[head], combinationally from registered state only (no bypass from free port).
- REQ-015 SHALL, on granted allocation, advance head by 1 and decrement count at the next edge.
- REQ-016 SHALL, on free_valid_i with count < PRF_SIZE, write free_preg_i to storage[tail], advance tail by 1 and increment count at the next edge.
- REQ-017 SHALL, on simultaneous grant and accepted free, update both pointers and leave count unchanged.
- REQ-018 SHALL make a freed preg allocatable no earlier than the cycle after the free (1-cycle latency), including when count == 0.
- REQ-019 SHALL ignore alloc_req_i when count == 0 (no pointer change, no error).
- REQ-020 SHALL ignore free_valid_i when count == PRF_SIZE and set error_o.
- REQ-021 SHALL, on flush_i, at the next edge load the reset state (REQ-024), overriding any same-cycle alloc or free; error_o is not cleared by flush.
- REQ-022 SHALL drive free_count_o = count.

Reset
- REQ-023 SHALL apply reset only on clk_i rising edge with rst_i high; rst_i overrides flush_i, alloc and free.
- REQ-024 SHALL reset to: storage[i] = i for i in 0..PRF_SIZE-1, head = 0, tail = 0, count = PRF_SIZE; so alloc_ready_o = 1, alloc_preg_o = 0, free_count_o = PRF_SIZE, error_o = 0.
- REQ-025 SHALL, on reset mid-operation, discard all outstanding allocations.

Configuration
- REQ-026 SHALL support macro FREELIST_CHECK_EN.
- REQ-027 With FREELIST_CHECK_EN defined: SHALL keep a PRF_SIZE-bit busy bitmap (reset/flush all 0); grant sets bit alloc_preg_o; accepted free clears bit free_preg_i; free of a preg whose bit is 0 (double free) SHALL set error_o and SHALL NOT enqueue it; same-cycle alloc and free of the same id is legal only if the bit was already 1.
- REQ-028 Without FREELIST_CHECK_EN: no bitmap; frees accepted unchecked except REQ-020; error_o set only by REQ-020.

Verification
- REQ-029 After reset, 16 back-to-back alloc_req_i -> alloc_preg_o 0,1,...,15 on successive cycles, then alloc_ready_o = 0, free_count_o = 0.
- REQ-030 From empty, free preg 7 in cycle N -> alloc_ready_o = 0 in N, = 1 in N+1 with alloc_preg_o = 7, free_count_o = 1.
- REQ-031 With count = 5, alloc and free (preg 3) same cycle -> count stays 5, head and tail each +1, 3 returned after the 4 older entries.
- REQ-032 After 20 alloc/free pairs (pointer wrap past 15) -> allocation order equals free order, free_count_o never exceeds 16.
- REQ-033 After reset, free preg 2 (list full) -> free ignored, error_o = 1 and stays 1 through flush; with FREELIST_CHECK_EN, alloc 0, free 0, free 0 again -> error_o = 1, count = 16 not 17.
- REQ-034 Allocate 6 then assert flush_i with simultaneous alloc_req_i -> next cycle free_count_o = 16, alloc_preg_o = 0.
